mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ROW_BITS SHALL be: ROW_BITS, default 13, memory address width; depth is 2^ROW_BITS words.
REQ-002 Parameter TIMEOUT_CYCLES SHALL be: TIMEOUT_CYCLES, default 255, maximum MEM_DONE wait, range 1..1023.
REQ-003 Parameter STARVE_LIMIT SHALL be: STARVE_LIMIT, default 4, consecutive write grants before a pending read is forced.
REQ-004 Port CLK_48MHZ SHALL be: CLK_48MHZ  input  1  sole clock, all logic on its rising edge.
REQ-005 Port RESET SHALL be: RESET  input  1  asynchronous, active-high reset.
REQ-006 Write-requester ports SHALL be: WR_REQ  input  1  level request; WR_DATA  input  16  write word; WR_ACK  output  1  one-cycle completion pulse.
REQ-007 Read-requester ports SHALL be: RD_REQ  input  1  level request; RD_DATA  output  16  read word; RD_VALID  output  1  one-cycle pulse, RD_DATA valid.
REQ-008 Memory ports SHALL be: MEM_REQ  output  1; MEM_WE  output  1; MEM_ADDR  output  ROW_BITS; MEM_WDATA  output  16; MEM_RDATA  input  16; MEM_DONE  input  1.
REQ-009 Status ports SHALL be: ROW_WRITE  output  ROW_BITS  write pointer; ROW_READ  output  ROW_BITS  read pointer; EMPTY  output  1; FULL  output  1; TIMEOUT_ERR  output  1  sticky.

Function
REQ-010 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; one transaction in flight at most.
REQ-011 IDLE SHALL sample WR_REQ/RD_REQ each cycle; eligible write = WR_REQ and not FULL; eligible read = RD_REQ and not EMPTY; none eligible -> stay IDLE.
REQ-012 Both eligible SHALL grant write, except when the starvation guard (REQ-024) forces read.
REQ-013 IDLE->ISSUE on grant: MEM_ADDR, MEM_WE, MEM_WDATA (= WR_DATA for writes) registered; MEM_REQ asserted the cycle after grant.
REQ-014 ISSUE->WAIT after one cycle; MEM_REQ, MEM_ADDR, MEM_WE, MEM_WDATA SHALL stay stable until MEM_DONE sampled high or timeout.
REQ-015 MEM_DONE high in ISSUE or WAIT -> DONE: MEM_REQ deasserts next cycle; write: WR_ACK pulses, write pointer +1; read: RD_DATA <= MEM_RDATA, RD_VALID pulses, read pointer +1.
REQ-016 DONE->IDLE unconditionally; minimum transaction = 4 cycles grant-to-IDLE, one idle cycle between back-to-back grants.
REQ-017 Pointers SHALL be ROW_BITS+1 bits internally (wrap bit); ROW_WRITE/ROW_READ = low ROW_BITS bits; increment wraps 2^ROW_BITS-1 -> 0, wrap bit toggles.
REQ-018 EMPTY = full pointers equal; FULL = low bits equal and wrap bits differ; both combinational from registered pointers.
REQ-019 Requesters hold REQ until ACK/VALID; REQ dropped mid-transaction SHALL NOT abort it.
REQ-020 Cycle counter starts at MEM_REQ assertion; TIMEOUT_CYCLES reached without MEM_DONE -> MEM_REQ drops, TIMEOUT_ERR sets, no pointer change, no ACK/VALID, state -> IDLE.
REQ-021 MEM_DONE outside ISSUE/WAIT SHALL be ignored.

Reset
REQ-022 RESET high SHALL immediately force IDLE, pointers 0, MEM_REQ/MEM_WE/WR_ACK/RD_VALID/TIMEOUT_ERR 0, MEM_ADDR/MEM_WDATA/RD_DATA 0, EMPTY 1, FULL 0, starve counter 0.
REQ-023 Reset mid-transaction SHALL abandon it with no pointer update; first grant no earlier than the second CLK_48MHZ edge after RESET falls.

Configuration
REQ-024 Macro MEM_ARB_STARVE_GUARD_EN defined: counter counts consecutive write grants while a read is eligible, clears on read grant; at STARVE_LIMIT the next both-eligible arbitration grants read. Undefined: strict write priority, counter absent.

Verification
REQ-025 Reset then WR_REQ with WR_DATA=16'hA5A5, MEM_DONE 2 cycles after MEM_REQ -> MEM_ADDR=0, MEM_WE=1, WR_ACK one pulse, ROW_WRITE=1, EMPTY=0.
REQ-026 After REQ-025, RD_REQ, MEM_RDATA=16'hA5A5 -> MEM_WE=0, MEM_ADDR=0, RD_VALID one pulse, RD_DATA=16'hA5A5, ROW_READ=1, EMPTY=1.
REQ-027 ROW_BITS=3, 8 writes no reads -> FULL=1, 9th WR_REQ never granted, MEM_REQ stays 0; one read -> FULL=0, write granted at MEM_ADDR=0.
REQ-028 WR_REQ and RD_REQ held continuously, data present, guard enabled -> pattern 4 writes then 1 read; guard disabled -> writes only until FULL.
REQ-029 MEM_DONE held low -> MEM_REQ drops after TIMEOUT_CYCLES (255) cycles, TIMEOUT_ERR=1 until RESET, pointers unchanged.
REQ-030 RESET pulsed while in WAIT -> MEM_REQ=0 immediately, pointers 0, no WR_ACK/RD_VALID.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one write port and one read port share a single-ported
// memory that is addressed as a circular buffer. At most one memory transaction is in flight.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a pending read after
// STARVE_LIMIT consecutive write grants; otherwise writes always win.
module mem_arbiter #(
  parameter int unsigned ROW_BITS       = 13,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                CLK_48MHZ,
  input  logic                RESET,
  input  logic                WR_REQ,
  input  logic [15:0]         WR_DATA,
  output logic                WR_ACK,
  input  logic                RD_REQ,
  output logic [15:0]         RD_DATA,
  output logic                RD_VALID,
  output logic                MEM_REQ,
  output logic                MEM_WE,
  output logic [ROW_BITS-1:0] MEM_ADDR,
  output logic [15:0]         MEM_WDATA,
  input  logic [15:0]         MEM_RDATA,
  input  logic                MEM_DONE,
  output logic [ROW_BITS-1:0] ROW_WRITE,
  output logic [ROW_BITS-1:0] ROW_READ,
  output logic                EMPTY,
  output logic                FULL,
  output logic                TIMEOUT_ERR
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // Last count value before the wait limit expires; MEM_REQ is high for TIMEOUT_CYCLES cycles.
  localparam logic [9:0] TmoLast = 10'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [ROW_BITS:0] wr_ptr_q, rd_ptr_q;
  logic [9:0]        tmo_cnt_q;
  logic              rst_done_q;
  logic              mem_req_q, mem_we_q;
  logic [ROW_BITS-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q, rd_data_q;
  logic              wr_ack_q, rd_valid_q, tmo_err_q;

  logic empty, full, wr_elig, rd_elig, force_rd;
  logic grant_wr, grant_rd, finish, expire;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[ROW_BITS-1:0] == rd_ptr_q[ROW_BITS-1:0]) &&
                   (wr_ptr_q[ROW_BITS] != rd_ptr_q[ROW_BITS]);
  assign wr_elig = WR_REQ && !full;
  assign rd_elig = RD_REQ && !empty;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 2);
  logic [StarveW-1:0] starve_q;

  assign force_rd = (starve_q >= StarveW'(STARVE_LIMIT));

  // Count writes granted while a read was waiting; any read grant clears the run.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      starve_q <= '0;
    end else if (grant_rd) begin
      starve_q <= '0;
    end else if (grant_wr && rd_elig) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign force_rd = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: arbitration in idle, completion/timeout while the request is out.
  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    finish   = 1'b0;
    expire   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // rst_done_q holds off the first grant for one edge after reset release
        if (rst_done_q) begin
          if (wr_elig && !(rd_elig && force_rd)) begin
            grant_wr = 1'b1;
          end else if (rd_elig) begin
            grant_rd = 1'b1;
          end
          if (grant_wr || grant_rd) state_d = StIssue;
        end
      end
      StIssue, StWait: begin
        if (MEM_DONE) begin
          finish  = 1'b1;
          state_d = StDone;
        end else if (tmo_cnt_q == TmoLast) begin
          expire  = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StWait;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory request, pointers, completion pulses and the wait counter.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      rst_done_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      wr_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      tmo_err_q   <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      if (grant_wr || grant_rd) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= grant_wr;
        mem_addr_q <= grant_wr ? wr_ptr_q[ROW_BITS-1:0] : rd_ptr_q[ROW_BITS-1:0];
        if (grant_wr) mem_wdata_q <= WR_DATA;
        tmo_cnt_q  <= '0;
      end else if (finish) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        if (mem_we_q) begin
          wr_ack_q <= 1'b1;
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end else begin
          rd_data_q  <= MEM_RDATA;
          rd_valid_q <= 1'b1;
          rd_ptr_q   <= rd_ptr_q + 1'b1;
        end
      end else if (expire) begin
        mem_req_q <= 1'b0;
        mem_we_q  <= 1'b0;
        tmo_err_q <= 1'b1;
      end else if (mem_req_q) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  assign WR_ACK      = wr_ack_q;
  assign RD_DATA     = rd_data_q;
  assign RD_VALID    = rd_valid_q;
  assign MEM_REQ     = mem_req_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign ROW_WRITE   = wr_ptr_q[ROW_BITS-1:0];
  assign ROW_READ    = rd_ptr_q[ROW_BITS-1:0];
  assign EMPTY       = empty;
  assign FULL        = full;
  assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model (write/read counts, a FIFO of written words,
// a request-age counter) is checked against the DUT every cycle, with directed scenarios
// carrying literal expectations followed by a randomized run.
module tb_mem_arbiter;

  localparam int unsigned RB    = 3;
  localparam int unsigned DEPTH = 1 << RB;
  localparam int unsigned TMO   = 255;
  localparam int unsigned STARV = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RESET = 1'b0;
  logic          WR_REQ = 1'b0, RD_REQ = 1'b0, MEM_DONE = 1'b0;
  logic [15:0]   WR_DATA = '0, MEM_RDATA = '0;
  logic          WR_ACK, RD_VALID, MEM_REQ, MEM_WE, EMPTY, FULL, TIMEOUT_ERR;
  logic [15:0]   RD_DATA, MEM_WDATA;
  logic [RB-1:0] MEM_ADDR, ROW_WRITE, ROW_READ;

  mem_arbiter #(.ROW_BITS(RB), .TIMEOUT_CYCLES(TMO), .STARVE_LIMIT(STARV)) dut (
    .CLK_48MHZ(clk), .RESET(RESET),
    .WR_REQ(WR_REQ), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
    .RD_REQ(RD_REQ), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_DONE(MEM_DONE),
    .ROW_WRITE(ROW_WRITE), .ROW_READ(ROW_READ), .EMPTY(EMPTY), .FULL(FULL),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // Stimulus intent, applied at each falling edge.
  logic i_rst = 1'b1, i_wr = 1'b0, i_rd = 1'b0, i_stall = 1'b0, i_noise = 1'b0;
  logic [15:0] i_wdata = '0;
  int i_delay = -1;

  // Memory responder.
  logic [15:0] mem_arr [DEPTH];
  int r_cnt = 0, r_delay = 0;

  // Behavioural model.
  int          m_nw = 0, m_nr = 0, m_age = 0, m_starve = 0;
  bit          m_active = 0, m_hold = 1, m_err = 0, m_ack = 0, m_valid = 0, m_we = 0;
  logic [RB-1:0] m_addr = '0;
  logic [15:0] m_wdata = '0, m_rdata = '0;
  logic [15:0] wq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("mem_req", 32'(MEM_REQ), 32'(m_active));
    if (m_active) begin
      chk("mem_we", 32'(MEM_WE), 32'(m_we));
      chk("mem_addr", 32'(MEM_ADDR), 32'(m_addr));
      if (m_we) chk("mem_wdata", 32'(MEM_WDATA), 32'(m_wdata));
    end
    chk("wr_ack", 32'(WR_ACK), 32'(m_ack));
    chk("rd_valid", 32'(RD_VALID), 32'(m_valid));
    if (m_valid) chk("rd_data", 32'(RD_DATA), 32'(m_rdata));
    chk("row_write", 32'(ROW_WRITE), 32'(m_nw % DEPTH));
    chk("row_read", 32'(ROW_READ), 32'(m_nr % DEPTH));
    chk("empty", 32'(EMPTY), 32'(m_nw == m_nr));
    chk("full", 32'(FULL), 32'((m_nw - m_nr) == DEPTH));
    chk("timeout_err", 32'(TIMEOUT_ERR), 32'(m_err));
    if (RESET) begin
      chk("rst_mem_we", 32'(MEM_WE), 0);
      chk("rst_mem_addr", 32'(MEM_ADDR), 0);
      chk("rst_mem_wdata", 32'(MEM_WDATA), 0);
      chk("rst_rd_data", 32'(RD_DATA), 0);
    end
  endtask

  task automatic drive();
    RESET   = i_rst;
    WR_REQ  = i_wr;
    RD_REQ  = i_rd;
    WR_DATA = i_wdata;
    if (MEM_REQ && !RESET) begin
      if (r_cnt == 0) r_delay = (i_delay < 0) ? int'($urandom_range(0, 4)) : i_delay;
      MEM_DONE  = !i_stall && (r_cnt >= r_delay);
      MEM_RDATA = mem_arr[MEM_ADDR];
      if (MEM_DONE && MEM_WE) mem_arr[MEM_ADDR] = MEM_WDATA;
      r_cnt++;
    end else begin
      r_cnt     = 0;
      MEM_DONE  = i_noise && ($urandom_range(0, 7) == 0);
      MEM_RDATA = 16'($urandom);
    end
  endtask

  // Predict the outputs after the coming rising edge from the inputs now applied.
  task automatic advance();
    int occ;
    bit ew, er, rd_win;
    m_ack = 0;
    m_valid = 0;
    if (RESET) begin
      m_nw = 0; m_nr = 0; m_active = 0; m_err = 0; m_hold = 1; m_starve = 0;
      wq.delete();
      return;
    end
    if (m_active) begin
      if (MEM_DONE) begin
        m_active = 0;
        m_hold = 1;
        if (m_we) begin
          m_nw++; m_ack = 1; wq.push_back(m_wdata);
        end else begin
          m_nr++; m_valid = 1;
          m_rdata = (wq.size() > 0) ? wq.pop_front() : 16'hDEAD;
        end
      end else if (m_age == TMO) begin
        m_active = 0;
        m_err = 1;
      end else begin
        m_age++;
      end
    end else if (m_hold) begin
      m_hold = 0;
    end else begin
      occ = m_nw - m_nr;
      ew = WR_REQ && (occ < DEPTH);
      er = RD_REQ && (occ > 0);
      if (ew || er) begin
        rd_win = er && (!ew || (GUARD && m_starve >= STARV));
        m_active = 1;
        m_age = 1;
        m_we = !rd_win;
        if (rd_win) begin
          m_addr = RB'(m_nr % DEPTH);
          m_starve = 0;
        end else begin
          m_addr = RB'(m_nw % DEPTH);
          m_wdata = WR_DATA;
          if (er && GUARD) m_starve++;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    drive();
    advance();
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 50; k++) begin
      step();
      if (MEM_REQ) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s: MEM_REQ stayed 0, required 1 within 50 cycles", name);
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_stall = 1'b0;
    repeat (2) step();
    i_rst = 1'b0;
    step();
  endtask

  initial begin
    int acks, vals, hi, g;
    logic prev;
    logic [6:0] seq, exp_seq;
    logic [15:0] got;
    for (int k = 0; k < DEPTH; k++) mem_arr[k] = '0;
    #1 RESET = 1'b1;

    // Reset state, then one write of A5A5.
    repeat (3) step();
    chk("rst_empty", 32'(EMPTY), 1);
    chk("rst_full", 32'(FULL), 0);
    chk("rst_mem_req", 32'(MEM_REQ), 0);
    i_rst = 1'b0; i_delay = 2; i_wr = 1'b1; i_wdata = 16'hA5A5;
    wait_req("a_grant");
    chk("a_addr", 32'(MEM_ADDR), 0);
    chk("a_we", 32'(MEM_WE), 1);
    chk("a_wdata", 32'(MEM_WDATA), 32'hA5A5);
    acks = 0;
    repeat (8) begin
      step();
      if (WR_ACK) begin acks++; i_wr = 1'b0; end
    end
    chk("a_ack_pulses", 32'(acks), 1);
    chk("a_row_write", 32'(ROW_WRITE), 1);
    chk("a_empty", 32'(EMPTY), 0);

    // Read it back.
    i_rd = 1'b1;
    wait_req("b_grant");
    chk("b_we", 32'(MEM_WE), 0);
    chk("b_addr", 32'(MEM_ADDR), 0);
    vals = 0; got = '0;
    repeat (8) begin
      step();
      if (RD_VALID) begin vals++; got = RD_DATA; i_rd = 1'b0; end
    end
    chk("b_valid_pulses", 32'(vals), 1);
    chk("b_rd_data", 32'(got), 32'hA5A5);
    chk("b_row_read", 32'(ROW_READ), 1);
    chk("b_empty", 32'(EMPTY), 1);

    // Fill to FULL, confirm writes are refused, free one slot.
    do_reset();
    i_delay = -1; i_wr = 1'b1; acks = 0;
    for (int k = 0; k < 200 && acks < DEPTH; k++) begin
      i_wdata = 16'($urandom);
      step();
      if (WR_ACK) acks++;
    end
    chk("c_acks", 32'(acks), DEPTH);
    step();
    chk("c_full", 32'(FULL), 1);
    hi = 0;
    repeat (20) begin step(); if (MEM_REQ) hi++; end
    chk("c_no_grant_full", 32'(hi), 0);
    i_rd = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      if (RD_VALID) begin i_rd = 1'b0; break; end
    end
    chk("c_rd_done", 32'(ROW_READ), 1);
    wait_req("c_regrant");
    chk("c_wr_addr", 32'(MEM_ADDR), 0);
    chk("c_wr_we", 32'(MEM_WE), 1);
    chk("c_not_full", 32'(FULL), 0);
    i_wr = 1'b0;
    repeat (10) step();

    // Both requesters held with data present: grant pattern.
    do_reset();
    i_wr = 1'b1; acks = 0;
    for (int k = 0; k < 100 && acks < 2; k++) begin
      step();
      if (WR_ACK) acks++;
    end
    i_wr = 1'b0;
    repeat (2) step();
    i_wr = 1'b1; i_rd = 1'b1; g = 0; seq = '0; prev = MEM_REQ;
    for (int k = 0; k < 300 && g < 7; k++) begin
      i_wdata = 16'($urandom);
      step();
      if (MEM_REQ && !prev) begin seq[g] = MEM_WE; g++; end
      prev = MEM_REQ;
    end
    exp_seq = GUARD ? 7'b1101111 : 7'b0111111;
    chk("d_grant_count", 32'(g), 7);
    chk("d_grant_seq", 32'(seq), 32'(exp_seq));
    i_wr = 1'b0; i_rd = 1'b0;
    repeat (10) step();

    // Memory never answers: timeout after TMO cycles, sticky error.
    do_reset();
    i_stall = 1'b1; i_wr = 1'b1; i_wdata = 16'h1234;
    wait_req("e_grant");
    i_wr = 1'b0;
    hi = 1;
    for (int k = 0; k < 400; k++) begin
      step();
      if (MEM_REQ) hi++; else break;
    end
    chk("e_req_cycles", 32'(hi), TMO);
    chk("e_err", 32'(TIMEOUT_ERR), 1);
    chk("e_row_write", 32'(ROW_WRITE), 0);
    chk("e_empty", 32'(EMPTY), 1);
    repeat (10) step();
    chk("e_err_sticky", 32'(TIMEOUT_ERR), 1);
    do_reset();
    chk("e_err_cleared", 32'(TIMEOUT_ERR), 0);

    // Reset while waiting on memory.
    i_stall = 1'b1; i_wr = 1'b1;
    wait_req("f_grant");
    repeat (3) step();
    i_rst = 1'b1;
    step();
    #1;
    chk("f_req_dropped", 32'(MEM_REQ), 0);
    i_rst = 1'b0; i_stall = 1'b0; i_wr = 1'b0;
    acks = 0;
    repeat (10) begin step(); if (WR_ACK || RD_VALID) acks++; end
    chk("f_no_ack", 32'(acks), 0);
    chk("f_row_write", 32'(ROW_WRITE), 0);

    // Randomized traffic.
    i_noise = 1'b1; i_delay = -1;
    for (int k = 0; k < 4000; k++) begin
      i_wr = ($urandom_range(0, 3) != 0);
      i_rd = ($urandom_range(0, 3) != 0);
      i_wdata = 16'($urandom);
      i_rst = ($urandom_range(0, 599) == 0);
      step();
    end
    i_rst = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
    repeat (10) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
